branch_predictor: RTL and testbench

Dynamic branch predictor for the ID stage of the MIPS pipeline. It holds a PC-indexed table of 2-bit saturating counters and, for each branch being decoded, produces the predicted direction and target that ID registers into the ID/EX latch (branch_prediction_in / branch_target_addr_in). EX writes each resolved outcome back into the table the following clock edge. Optional statistics counters track resolved branches and mispredictions.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 73 +++++++
 tb/tb_branch_predictor.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Lookup/update/statistics bundle between the ID/EX stages and the branch
// predictor. The pipeline side uses the master modport, the predictor uses slave.
interface branch_predictor_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  lookup_is_branch;
  logic [DATA_WIDTH-1:0] lookup_pc;
  logic [DATA_WIDTH-1:0] lookup_imm;
  logic                  prediction_taken;
  logic [DATA_WIDTH-1:0] prediction_target;
  logic                  update_valid;
  logic [DATA_WIDTH-1:0] update_pc;
  logic                  update_taken;
  logic                  update_mispredict;
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;

  modport master (
    output lookup_is_branch, lookup_pc, lookup_imm,
    output update_valid, update_pc, update_taken, update_mispredict,
    input  prediction_taken, prediction_target,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  lookup_is_branch, lookup_pc, lookup_imm,
    input  update_valid, update_pc, update_taken, update_mispredict,
    output prediction_taken, prediction_target,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the ID stage: PC-indexed table of 2-bit
// saturating counters, combinational lookup, one update per clock from EX.
// Optional statistics counters are built only when BRANCH_PRED_STATS_EN is
// defined; otherwise stat_branches/stat_mispredicts read 0.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [1:0]            ctr_q [DEPTH];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic                  unused_ok;

  assign lookup_idx = bus.lookup_pc[INDEX_BITS+1:2];
  assign update_idx = bus.update_pc[INDEX_BITS+1:2];
  // Only the index slice of update_pc matters; aliasing is intentional.
  assign unused_ok  = ^{bus.update_pc, bus.update_mispredict};

  // Lookup: direction from the current table state, target always computed.
  always_comb begin
    bus.prediction_taken  = bus.lookup_is_branch & ctr_q[lookup_idx][1];
    bus.prediction_target = bus.lookup_pc + DATA_WIDTH'(4) + (bus.lookup_imm << 2);
  end

  // Counter table: reset to weak-NT, saturating increment/decrement on update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (bus.update_valid) begin
      if (bus.update_taken) begin
        if (ctr_q[update_idx] != 2'b11) ctr_q[update_idx] <= ctr_q[update_idx] + 2'b01;
      end else begin
        if (ctr_q[update_idx] != 2'b00) ctr_q[update_idx] <= ctr_q[update_idx] - 2'b01;
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispredicts_q;

  // Statistics: count resolved branches and mispredictions, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (bus.update_valid) begin
      if (branches_q != '1) branches_q <= branches_q + 32'd1;
      if (bus.update_mispredict && (mispredicts_q != '1)) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  // Statistics outputs come straight from the counters.
  always_comb begin
    bus.stat_branches    = branches_q;
    bus.stat_mispredicts = mispredicts_q;
  end
`else
  // Statistics disabled: outputs tied low.
  always_comb begin
    bus.stat_branches    = '0;
    bus.stat_mispredicts = '0;
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (INDEX_BITS=6, DATA_WIDTH=32).
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  branch_predictor_if #(.DATA_WIDTH(32)) bus ();

  branch_predictor #(.INDEX_BITS(6), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] imm, input logic br);
    bus.lookup_pc        = pc;
    bus.lookup_imm       = imm;
    bus.lookup_is_branch = br;
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic misp);
    bus.update_valid      = 1'b1;
    bus.update_pc         = pc;
    bus.update_taken      = taken;
    bus.update_mispredict = misp;
    tick();
    bus.update_valid      = 1'b0;
    bus.update_mispredict = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    bus.update_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.update_valid      = 1'b0;
    bus.update_pc         = '0;
    bus.update_taken      = 1'b0;
    bus.update_mispredict = 1'b0;
    apply_reset();
    lookup(32'h40, 32'h3, 1'b1);
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_taken: got %b expected 0", bus.prediction_taken);
    end
    checks++;
    if (bus.prediction_target !== 32'h50) begin
      failures++;
      $display("FAIL reset_target: got %h expected 00000050", bus.prediction_target);
    end
    checks++;
    if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", bus.stat_branches, bus.stat_mispredicts);
    end
  endtask

  // 01 -> 10 (taken) -> 11 -> 11 (saturate) -> 10 (taken) -> 01 (not taken)
  task automatic test_train_taken();
    logic exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic tk_seq  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    lookup(32'h40, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_update(32'h40, tk_seq[i], 1'b0);
      checks++;
      if (bus.prediction_taken !== exp_seq[i]) begin
        failures++;
        $display("FAIL train_taken step %0d: got %b expected %b", i, bus.prediction_taken, exp_seq[i]);
      end
    end
  endtask

  // Four NT saturate at 00; then taken -> 01 (NT), taken -> 10 (T).
  task automatic test_saturate_nt();
    apply_reset();
    lookup(32'h80, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) do_update(32'h80, 1'b0, 1'b0);
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_nt_floor: got %b expected 0", bus.prediction_taken);
    end
    do_update(32'h80, 1'b1, 1'b0);
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_nt_one_up: got %b expected 0", bus.prediction_taken);
    end
    do_update(32'h80, 1'b1, 1'b0);
    checks++;
    if (bus.prediction_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_nt_two_up: got %b expected 1", bus.prediction_taken);
    end
  endtask

  task automatic test_no_bypass_alias();
    apply_reset();
    lookup(32'h40, 32'h0, 1'b1);
    bus.update_valid = 1'b1;
    bus.update_pc    = 32'h40;
    bus.update_taken = 1'b1;
    #1;
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass_same_cycle: got %b expected 0", bus.prediction_taken);
    end
    tick();
    bus.update_valid = 1'b0;
    #1;
    checks++;
    if (bus.prediction_taken !== 1'b1) begin
      failures++;
      $display("FAIL no_bypass_next_cycle: got %b expected 1", bus.prediction_taken);
    end
    lookup(32'h140, 32'h0, 1'b1);
    checks++;
    if (bus.prediction_taken !== 1'b1) begin
      failures++;
      $display("FAIL alias_0x140: got %b expected 1", bus.prediction_taken);
    end
    lookup(32'h44, 32'h0, 1'b1);
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL neighbour_0x44: got %b expected 0", bus.prediction_taken);
    end
  endtask

  task automatic test_target_and_gating();
    lookup(32'h10, 32'hFFFF_FFFE, 1'b1);
    checks++;
    if (bus.prediction_target !== 32'h0000_000C) begin
      failures++;
      $display("FAIL target_neg_imm: got %h expected 0000000c", bus.prediction_target);
    end
    lookup(32'h1000, 32'h0000_0100, 1'b1);
    checks++;
    if (bus.prediction_target !== 32'h0000_1404) begin
      failures++;
      $display("FAIL target_pos_imm: got %h expected 00001404", bus.prediction_target);
    end
    apply_reset();
    do_update(32'h40, 1'b1, 1'b0);
    do_update(32'h40, 1'b1, 1'b0);
    lookup(32'h40, 32'h0, 1'b0);
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL not_branch_taken: got %b expected 0", bus.prediction_taken);
    end
    // update_valid low: taken inputs must not move entry 0xC0 off weak-NT
    bus.update_valid = 1'b0;
    bus.update_pc    = 32'hC0;
    bus.update_taken = 1'b1;
    tick();
    tick();
    lookup(32'hC0, 32'h0, 1'b1);
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL update_gated: got %b expected 0", bus.prediction_taken);
    end
  endtask

  task automatic test_reset_collision();
    lookup(32'h100, 32'h0, 1'b1);
    reset            = 1'b1;
    bus.update_valid = 1'b1;
    bus.update_pc    = 32'h100;
    bus.update_taken = 1'b1;
    tick();
    bus.update_valid = 1'b0;
    reset            = 1'b0;
    #1;
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL update_during_reset: got %b expected 0", bus.prediction_taken);
    end
    do_update(32'h100, 1'b1, 1'b0);
    checks++;
    if (bus.prediction_taken !== 1'b1) begin
      failures++;
      $display("FAIL first_update_after_reset: got %b expected 1", bus.prediction_taken);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_b;
    logic [31:0] exp_m;
`ifdef BRANCH_PRED_STATS_EN
    exp_b = 32'd3;
    exp_m = 32'd1;
`else
    exp_b = 32'd0;
    exp_m = 32'd0;
`endif
    apply_reset();
    do_update(32'h200, 1'b1, 1'b0);
    do_update(32'h200, 1'b1, 1'b1);
    do_update(32'h204, 1'b0, 1'b0);
    // mispredict without update_valid must not count
    bus.update_mispredict = 1'b1;
    tick();
    bus.update_mispredict = 1'b0;
    checks++;
    if (bus.stat_branches !== exp_b) begin
      failures++;
      $display("FAIL stat_branches: got %0d expected %0d", bus.stat_branches, exp_b);
    end
    checks++;
    if (bus.stat_mispredicts !== exp_m) begin
      failures++;
      $display("FAIL stat_mispredicts: got %0d expected %0d", bus.stat_mispredicts, exp_m);
    end
    // asynchronous reset between edges clears stats and table at once
    lookup(32'h200, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_stats: got %0d/%0d expected 0/0", bus.stat_branches, bus.stat_mispredicts);
    end
    checks++;
    if (bus.prediction_taken !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_table: got %b expected 0", bus.prediction_taken);
    end
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset                 = 1'b1;
    bus.lookup_is_branch  = 1'b0;
    bus.lookup_pc         = '0;
    bus.lookup_imm        = '0;
    bus.update_valid      = 1'b0;
    bus.update_pc         = '0;
    bus.update_taken      = 1'b0;
    bus.update_mispredict = 1'b0;
    #2;
    test_reset();
    test_train_taken();
    test_saturate_nt();
    test_no_bypass_alias();
    test_target_and_gating();
    test_reset_collision();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
